dcache_controller: RTL
======================

Name: dcache_controller

Overview:
- MEM-stage data cache controller. Sits between EX_MEM (address, store data, MemRead/MemWrite) and MEM_WB (read data, stall).
- Direct-mapped, write-back, write-allocate cache in front of a slow block-wide data memory.
- Asserts stall to freeze the whole pipeline, including MEM_WB, until the access completes.

Parameters:
- NUM_LINES, 32, number of cache lines (power of 2).
- BLOCK_WORDS, 8, 32-bit words per line (power of 2); block width = 32*BLOCK_WORDS.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- p1_MemRead_i  in  1  load request from EX_MEM.
- p1_MemWrite_i  in  1  store request from EX_MEM.
- p1_addr_i  in  ADDR_W  byte address.
- p1_data_i  in  32  store data.
- p1_data_o  out  32  load data to MEM_WB.ReadData_i.
- p1_stall_o  out  1  pipeline stall; drives MEM_WB.stall_i and the upstream stage registers.
- mem_enable_o  out  1  memory request valid.
- mem_write_o  out  1  1 = block write-back, 0 = block fetch.
- mem_addr_o  out  ADDR_W  block-aligned address; low log2(4*BLOCK_WORDS) bits are 0.
- mem_data_o  out  32*BLOCK_WORDS  write-back block.
- mem_ack_i  in  1  one-cycle pulse: request complete; fetch data valid in the same cycle.
- mem_data_i  in  32*BLOCK_WORDS  fetched block.

Behaviour:
- Address split (defaults):
  - addr[1:0] ignored.
  - word offset = addr[4:2].
  - index = addr[9:5].
  - tag = addr[31:10], 22 bits.
- req = p1_MemRead_i | p1_MemWrite_i. If both are high, the access is treated as a write.
- hit = valid[index] & (tag_array[index] == tag).
- Reset (async, rst_i low):
  - All valid and dirty bits cleared; state = IDLE.
  - mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0.
  - p1_stall_o = 0 while reset is held. The data array is not cleared.
  - A reset mid-transaction aborts it; a later mem_ack_i in IDLE is ignored.
- States: IDLE, WB_REQ, FILL_REQ, FILL_DONE.
  - IDLE, req & hit:
    - Read: p1_data_o = selected word combinationally, same cycle, no stall.
    - Write: word written and dirty set at the clock edge, no stall.
  - IDLE, req & ~hit: p1_stall_o = 1 combinationally. Next state is WB_REQ if valid & dirty, else FILL_REQ.
  - WB_REQ:
    - mem_enable_o = 1, mem_write_o = 1.
    - mem_addr_o = {old tag, index, 0}; mem_data_o = line data.
    - On mem_ack_i: clear dirty, go to FILL_REQ.
  - FILL_REQ:
    - mem_enable_o = 1, mem_write_o = 0, mem_addr_o = {tag, index, 0}.
    - On mem_ack_i: write mem_data_i to the line, set tag, valid = 1, dirty = 0, go to FILL_DONE.
  - FILL_DONE: mem_enable_o = 0, go to IDLE. The access then hits in IDLE and completes as a normal hit that cycle (write allocates and sets dirty).
- Memory handshake:
  - mem_enable_o and mem_addr_o/mem_data_o are registered outputs, held stable until the ack cycle and deasserted the cycle after.
  - mem_ack_i outside WB_REQ/FILL_REQ is ignored.
  - mem_enable_o is never high in IDLE or FILL_DONE.
- p1_stall_o = (state != IDLE) | (req & ~hit). Low in IDLE on a hit or with no request.
- p1_data_o = selected word when MemRead & hit in IDLE, else 32'h0.
- The request is held stable by the stalled pipeline; inputs during non-IDLE states must not alter state.
- Miss latency: clean miss = 2 + Tack cycles of stall; dirty miss = 3 + 2*Tack. Tack = cycles from request to ack (≥ 1).

Decomposition:
- Shared package:
  - state enum (IDLE, WB_REQ, FILL_REQ, FILL_DONE).
  - derived widths OFFSET_W, INDEX_W, TAG_W, BLOCK_W.
  - address-field extract functions.
- One sub-module, dcache_sram: tag/valid/dirty arrays plus data array.
  - Write ports: word write (hit store) and full-line write (fill).
  - Combinational read of index.
  - Reset clears valid and dirty only.

Test Plan:
- Cold read 0x0000_0040, memory returns block with word0 = 0xDEAD_BEEF, Tack = 3 → stall high 5 cycles, one FILL request at 0x40, then p1_data_o = 0xDEADBEEF with stall low.
- Repeat read 0x44 after fill → hit, no stall, mem_enable_o stays 0, data = word1 of the block.
- Store 0x1234_5678 to 0x48 (hit), then load 0x48 → 0x12345678, no memory traffic.
- Load 0x0000_0448 (same index 2, different tag, line dirty) → WB_REQ at 0x40 whose mem_data_o word2 = 0x12345678, then FILL at 0x440, then data returned.
- rst_i low during FILL_REQ, then ack arrives → state IDLE, all lines invalid, ack ignored, re-access of 0x40 misses.
- MemRead & MemWrite both high on a miss → handled as write-allocate; line ends dirty with the store word merged.

Source files
------------

// File: rtl/dcache_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller_pkg
//  Description : Shared types, default geometry and address-field helpers for
//                the MEM-stage data cache controller and its line storage.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_controller_pkg;

    // Default cache geometry
    localparam int DEF_NUM_LINES   = 32;
    localparam int DEF_BLOCK_WORDS = 8;
    localparam int DEF_ADDR_W      = 32;
    localparam int WORD_W          = 32;

    // Widths derived from the default geometry
    localparam int OFFSET_W = $clog2(DEF_BLOCK_WORDS);
    localparam int INDEX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W    = DEF_ADDR_W - INDEX_W - OFFSET_W - 2;
    localparam int BLOCK_W  = WORD_W * DEF_BLOCK_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WB_REQ    = 2'd1,
        ST_FILL_REQ  = 2'd2,
        ST_FILL_DONE = 2'd3
    } state_e;

    // Generic bit-field extraction; callers truncate the result to the
    // width of the field they asked for.
    function automatic logic [63:0] addr_field(input logic [63:0] addr,
                                               input int unsigned lsb,
                                               input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        return (addr >> lsb) & mask;
    endfunction

    // Byte-within-word bits [1:0] are never part of any field.
    function automatic logic [63:0] offset_of(input logic [63:0] addr,
                                              input int unsigned offset_w);
        return addr_field(addr, 2, offset_w);
    endfunction

    function automatic logic [63:0] index_of(input logic [63:0] addr,
                                             input int unsigned offset_w,
                                             input int unsigned index_w);
        return addr_field(addr, 2 + offset_w, index_w);
    endfunction

    function automatic logic [63:0] tag_of(input logic [63:0] addr,
                                           input int unsigned offset_w,
                                           input int unsigned index_w,
                                           input int unsigned tag_w);
        return addr_field(addr, 2 + offset_w + index_w, tag_w);
    endfunction

endpackage : dcache_controller_pkg
`default_nettype wire

// File: rtl/dcache_sram.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_sram
//  Description : Direct-mapped line storage: tag, valid, dirty and data
//                arrays with a combinational read of one index.
//  Ports       : clk_i/rst_i      clock, async active-low reset (valid/dirty)
//                i_index          line selected for read and all writes
//                o_valid/o_dirty/o_tag/o_line  contents of that line
//                i_word_we/i_word_offset/i_word_data  single-word store,
//                                 marks the line dirty
//                i_line_we/i_line_tag/i_line_data     full-line fill,
//                                 line becomes valid and clean
//                i_clear_dirty    line written back to memory
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_sram
    import dcache_controller_pkg::*;
#(
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int TAG_BITS    = TAG_W
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [$clog2(NUM_LINES)-1:0]  i_index,
    output logic                          o_valid,
    output logic                          o_dirty,
    output logic [TAG_BITS-1:0]           o_tag,
    output logic [32*BLOCK_WORDS-1:0]     o_line,
    input  logic                          i_word_we,
    input  logic [$clog2(BLOCK_WORDS)-1:0] i_word_offset,
    input  logic [31:0]                   i_word_data,
    input  logic                          i_line_we,
    input  logic [TAG_BITS-1:0]           i_line_tag,
    input  logic [32*BLOCK_WORDS-1:0]     i_line_data,
    input  logic                          i_clear_dirty
);

    localparam int c_BLOCK_W = 32 * BLOCK_WORDS;

    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [NUM_LINES-1:0] dirty_q, dirty_d;
    logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
    logic [c_BLOCK_W-1:0] data_q [NUM_LINES];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (i_line_we) begin
            valid_d[i_index] = 1'b1;
            dirty_d[i_index] = 1'b0;
        end
        if (i_clear_dirty) begin
            dirty_d[i_index] = 1'b0;
        end
        if (i_word_we) begin
            dirty_d[i_index] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and data arrays keep their contents across reset; a cleared valid
    // bit is enough to make every line miss.
    always_ff @(posedge clk_i) begin
        if (i_line_we) begin
            tag_q[i_index]  <= i_line_tag;
            data_q[i_index] <= i_line_data;
        end else if (i_word_we) begin
            data_q[i_index][{i_word_offset, 5'd0} +: 32] <= i_word_data;
        end
    end

    assign o_valid = valid_q[i_index];
    assign o_dirty = dirty_q[i_index];
    assign o_tag   = tag_q[i_index];
    assign o_line  = data_q[i_index];

endmodule : dcache_sram
`default_nettype wire

// File: rtl/dcache_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_controller
//  Description : MEM-stage direct-mapped, write-back, write-allocate data
//                cache controller in front of a block-wide data memory.
//  Ports       : clk_i, rst_i (async active-low)
//                p1_MemRead_i/p1_MemWrite_i/p1_addr_i/p1_data_i  request
//                p1_data_o     load data (0 unless a load hits in IDLE)
//                p1_stall_o    freezes the pipeline until the access ends
//                mem_enable_o/mem_write_o/mem_addr_o/mem_data_o  registered
//                              block request (write-back or fetch)
//                mem_ack_i/mem_data_i  completion pulse and fetched block
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int ADDR_W      = DEF_ADDR_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      p1_MemRead_i,
    input  logic                      p1_MemWrite_i,
    input  logic [ADDR_W-1:0]         p1_addr_i,
    input  logic [31:0]               p1_data_i,
    output logic [31:0]               p1_data_o,
    output logic                      p1_stall_o,
    output logic                      mem_enable_o,
    output logic                      mem_write_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [32*BLOCK_WORDS-1:0] mem_data_o,
    input  logic                      mem_ack_i,
    input  logic [32*BLOCK_WORDS-1:0] mem_data_i
);

    localparam int c_OFFSET_W = $clog2(BLOCK_WORDS);
    localparam int c_INDEX_W  = $clog2(NUM_LINES);
    localparam int c_LOW_W    = c_OFFSET_W + 2;
    localparam int c_TAG_W    = ADDR_W - c_INDEX_W - c_LOW_W;
    localparam int c_BLOCK_W  = 32 * BLOCK_WORDS;

    state_e state_q, state_d;

    logic                  mem_enable_q, mem_enable_d;
    logic                  mem_write_q,  mem_write_d;
    logic [ADDR_W-1:0]     mem_addr_q,   mem_addr_d;
    logic [c_BLOCK_W-1:0]  mem_data_q,   mem_data_d;

    logic [c_OFFSET_W-1:0] w_offset;
    logic [c_INDEX_W-1:0]  w_index;
    logic [c_TAG_W-1:0]    w_tag;
    logic                  w_req, w_hit, w_ack;
    logic [31:0]           w_word;

    logic                  rd_valid, rd_dirty;
    logic [c_TAG_W-1:0]    rd_tag;
    logic [c_BLOCK_W-1:0]  rd_line;

    logic                  word_we, line_we, clear_dirty;

    assign w_offset = c_OFFSET_W'(offset_of(64'(p1_addr_i), c_OFFSET_W));
    assign w_index  = c_INDEX_W'(index_of(64'(p1_addr_i), c_OFFSET_W, c_INDEX_W));
    assign w_tag    = c_TAG_W'(tag_of(64'(p1_addr_i), c_OFFSET_W, c_INDEX_W, c_TAG_W));

    assign w_req  = p1_MemRead_i | p1_MemWrite_i;
    assign w_hit  = rd_valid & (rd_tag == w_tag);
    assign w_word = rd_line[{w_offset, 5'd0} +: 32];
    // Only an ack against an outstanding request counts; stray pulses after
    // a reset or in the gap between write-back and fill are dropped.
    assign w_ack  = mem_ack_i & mem_enable_q;

    dcache_sram #(
        .NUM_LINES   (NUM_LINES),
        .BLOCK_WORDS (BLOCK_WORDS),
        .TAG_BITS    (c_TAG_W)
    ) u_sram (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_index       (w_index),
        .o_valid       (rd_valid),
        .o_dirty       (rd_dirty),
        .o_tag         (rd_tag),
        .o_line        (rd_line),
        .i_word_we     (word_we),
        .i_word_offset (w_offset),
        .i_word_data   (p1_data_i),
        .i_line_we     (line_we),
        .i_line_tag    (w_tag),
        .i_line_data   (mem_data_i),
        .i_clear_dirty (clear_dirty)
    );

    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        word_we      = 1'b0;
        line_we      = 1'b0;
        clear_dirty  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_hit) begin
                        // MemWrite wins when both strobes are high.
                        word_we = p1_MemWrite_i;
                    end else if (rd_valid && rd_dirty) begin
                        state_d      = ST_WB_REQ;
                        mem_enable_d = 1'b1;
                        mem_write_d  = 1'b1;
                        mem_addr_d   = {rd_tag, w_index, {c_LOW_W{1'b0}}};
                        mem_data_d   = rd_line;
                    end else begin
                        state_d      = ST_FILL_REQ;
                        mem_enable_d = 1'b1;
                        mem_write_d  = 1'b0;
                        mem_addr_d   = {w_tag, w_index, {c_LOW_W{1'b0}}};
                    end
                end
            end
            ST_WB_REQ: begin
                if (w_ack) begin
                    clear_dirty  = 1'b1;
                    state_d      = ST_FILL_REQ;
                    mem_enable_d = 1'b0;
                    mem_write_d  = 1'b0;
                end
            end
            ST_FILL_REQ: begin
                if (w_ack) begin
                    line_we      = 1'b1;
                    state_d      = ST_FILL_DONE;
                    mem_enable_d = 1'b0;
                end else begin
                    // Re-issues the fetch after the idle cycle that follows
                    // a write-back ack; a no-op when already requesting.
                    mem_enable_d = 1'b1;
                    mem_write_d  = 1'b0;
                    mem_addr_d   = {w_tag, w_index, {c_LOW_W{1'b0}}};
                end
            end
            ST_FILL_DONE: begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
            default: begin
                state_d      = ST_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= ST_IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

    // Gated by rst_i so a pending request sees no stall while reset is held
    // (all lines are invalid then and would otherwise look like a miss).
    assign p1_stall_o   = rst_i & ((state_q != ST_IDLE) | (w_req & ~w_hit));
    assign p1_data_o    = ((state_q == ST_IDLE) && p1_MemRead_i && w_hit) ? w_word : 32'h0;

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

endmodule : dcache_controller
`default_nettype wire
